reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 28 ++
 rtl/reg_file.sv | 42 ++++
 tb/tb_reg_file.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// reg_file_if: commit/issue/read bus between ROB, decoder and the register file.
interface reg_file_if;
  logic rdy;
  logic flush;
  logic commit_enable;
  logic [4:0] commit_rd;
  logic [31:0] commit_value;
  logic [4:0] commit_rename;
  logic issue_enable;
  logic [4:0] issue_rd;
  logic [4:0] issue_rename;
  logic [4:0] rs1_index;
  logic [4:0] rs2_index;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [4:0] rs1_rename;
  logic [4:0] rs2_rename;
  modport master (
    output rdy, flush, commit_enable, commit_rd, commit_value, commit_rename,
           issue_enable, issue_rd, issue_rename, rs1_index, rs2_index,
    input  rs1_value, rs2_value, rs1_rename, rs2_rename
  );
  modport slave (
    input  rdy, flush, commit_enable, commit_rd, commit_value, commit_rename,
           issue_enable, issue_rd, issue_rename, rs1_index, rs2_index,
    output rs1_value, rs2_value, rs1_rename, rs2_rename
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 architectural registers with ROB rename tags and commit bypass.
module reg_file #(
  parameter logic [4:0] NOTRENAME = 5'd16
) (
  input logic clk,
  input logic rst,
  reg_file_if.slave bus
);
  logic [31:0] vals [32];
  logic [4:0] tags [32];
  logic hit1, hit2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        vals[i] <= '0;
        tags[i] <= NOTRENAME;
      end
    end else if (bus.rdy) begin
      // x0 is never written, so it keeps its reset value of 0 / NOTRENAME
      for (int i = 1; i < 32; i++) begin
        if (bus.commit_enable && bus.commit_rd == 5'(i))
          vals[i] <= bus.commit_value;
        if (bus.flush)
          tags[i] <= NOTRENAME;
        else if (bus.issue_enable && bus.issue_rd == 5'(i))
          tags[i] <= bus.issue_rename;
        else if (bus.commit_enable && bus.commit_rd == 5'(i) && tags[i] == bus.commit_rename)
          tags[i] <= NOTRENAME;
      end
    end
  end
  always_comb begin
    hit1 = bus.commit_enable && bus.commit_rd == bus.rs1_index;
    hit2 = bus.commit_enable && bus.commit_rd == bus.rs2_index;
    bus.rs1_value = bus.rs1_index == 5'd0 ? 32'd0 : hit1 ? bus.commit_value : vals[bus.rs1_index];
    bus.rs2_value = bus.rs2_index == 5'd0 ? 32'd0 : hit2 ? bus.commit_value : vals[bus.rs2_index];
    bus.rs1_rename = (bus.rs1_index == 5'd0 || (hit1 && tags[bus.rs1_index] == bus.commit_rename))
                     ? NOTRENAME : tags[bus.rs1_index];
    bus.rs2_rename = (bus.rs2_index == 5'd0 || (hit2 && tags[bus.rs2_index] == bus.commit_rename))
                     ? NOTRENAME : tags[bus.rs2_index];
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors with a queue scoreboard checked by a negedge monitor.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk = 1'b0;
  int errors = 0;
  int checks = 0;
  typedef struct {
    string n;
    logic [31:0] v1;
    logic [4:0] t1;
    logic [31:0] v2;
    logic [4:0] t2;
  } exp_t;
  exp_t q[$];
  reg_file_if bus();
  reg_file dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic cmp(input string n, input string f, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got=%h want=%h", n, f, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (chk) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard empty at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.n, "rs1_value", bus.rs1_value, e.v1);
        cmp(e.n, "rs1_rename", 32'(bus.rs1_rename), 32'(e.t1));
        cmp(e.n, "rs2_value", bus.rs2_value, e.v2);
        cmp(e.n, "rs2_rename", 32'(bus.rs2_rename), 32'(e.t2));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    chk = 1'b0;
    bus.rdy = 1'b1;
    bus.flush = 1'b0;
    bus.commit_enable = 1'b0;
    bus.issue_enable = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    bus.rs1_index = a;
    bus.rs2_index = b;
  endtask
  task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [4:0] t);
    bus.commit_enable = 1'b1;
    bus.commit_rd = r;
    bus.commit_value = v;
    bus.commit_rename = t;
  endtask
  task automatic issue(input logic [4:0] r, input logic [4:0] t);
    bus.issue_enable = 1'b1;
    bus.issue_rd = r;
    bus.issue_rename = t;
  endtask
  task automatic expect_rd(input string n, input logic [31:0] v1, input logic [4:0] t1,
                           input logic [31:0] v2, input logic [4:0] t2);
    exp_t e;
    e.n = n; e.v1 = v1; e.t1 = t1; e.v2 = v2; e.t2 = t2;
    q.push_back(e);
    chk = 1'b1;
  endtask
  initial begin
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.commit_enable = 1'b0; bus.issue_enable = 1'b0;
    bus.commit_rd = '0; bus.commit_value = '0; bus.commit_rename = '0;
    bus.issue_rd = '0; bus.issue_rename = '0; rd(5'd5, 5'd0);
    tick(); rd(5'd5, 5'd0);
    expect_rd("reset", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); commit(5'd5, 32'h99, 5'd16); bus.flush = 1'b1; issue(5'd6, 5'd2); rd(5'd6, 5'd7);
    expect_rd("rst_commit_cycle", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); rd(5'd5, 5'd6);
    expect_rd("rst_blocks_update", 32'd0, 5'd16, 32'd0, 5'd16);
    rst = 1'b0;
    tick(); issue(5'd5, 5'd3); rd(5'd5, 5'd0);
    expect_rd("issue_not_fwd", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); rd(5'd5, 5'd0);
    expect_rd("issue_x5_t3", 32'd0, 5'd3, 32'd0, 5'd16);
    tick(); commit(5'd5, 32'hDEADBEEF, 5'd3); rd(5'd5, 5'd5);
    expect_rd("commit_bypass", 32'hDEADBEEF, 5'd16, 32'hDEADBEEF, 5'd16);
    tick(); rd(5'd5, 5'd0);
    expect_rd("commit_stored", 32'hDEADBEEF, 5'd16, 32'd0, 5'd16);
    tick(); issue(5'd5, 5'd7);
    tick(); commit(5'd5, 32'h11, 5'd3); rd(5'd5, 5'd0);
    expect_rd("old_commit_bypass", 32'h11, 5'd7, 32'd0, 5'd16);
    tick(); rd(5'd5, 5'd0);
    expect_rd("newer_tag_kept", 32'h11, 5'd7, 32'd0, 5'd16);
    tick(); issue(5'd6, 5'd2);
    tick(); commit(5'd6, 32'hCAFE, 5'd2); issue(5'd6, 5'd9); rd(5'd0, 5'd6);
    expect_rd("commit_issue_same", 32'd0, 5'd16, 32'hCAFE, 5'd16);
    tick(); rd(5'd0, 5'd6);
    expect_rd("issue_wins", 32'd0, 5'd16, 32'hCAFE, 5'd9);
    for (int i = 1; i <= 4; i++) begin
      tick(); issue(5'(i), 5'(i));
    end
    tick(); rd(5'd3, 5'd4);
    expect_rd("tags_x3_x4", 32'd0, 5'd3, 32'd0, 5'd4);
    tick(); bus.flush = 1'b1; issue(5'd7, 5'd5); commit(5'd1, 32'h42, 5'd1); rd(5'd1, 5'd2);
    expect_rd("flush_cycle", 32'h42, 5'd16, 32'd0, 5'd2);
    tick(); rd(5'd1, 5'd7);
    expect_rd("flush_x1_x7", 32'h42, 5'd16, 32'd0, 5'd16);
    tick(); rd(5'd4, 5'd6);
    expect_rd("flush_x4_x6", 32'd0, 5'd16, 32'hCAFE, 5'd16);
    tick(); issue(5'd0, 5'd5); commit(5'd0, 32'h55, 5'd16); rd(5'd0, 5'd0);
    expect_rd("x0_same_cycle", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); rd(5'd0, 5'd5);
    expect_rd("x0_after", 32'd0, 5'd16, 32'h11, 5'd16);
    tick(); bus.rdy = 1'b0; issue(5'd8, 5'd4); rd(5'd8, 5'd9);
    expect_rd("rdy_low_cycle", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); bus.rdy = 1'b0; commit(5'd9, 32'h77, 5'd16); bus.flush = 1'b1;
    tick(); rd(5'd8, 5'd9);
    expect_rd("rdy_low_hold", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); issue(5'd10, 5'd6); commit(5'd11, 32'h1234, 5'd0);
    tick(); rd(5'd10, 5'd11);
    expect_rd("pre_reset", 32'd0, 5'd6, 32'h1234, 5'd16);
    tick(); #1 rst = 1'b1; rd(5'd10, 5'd11);
    expect_rd("async_reset", 32'd0, 5'd16, 32'd0, 5'd16);
    tick(); rst = 1'b0; issue(5'd10, 5'd8);
    tick(); rd(5'd10, 5'd1);
    expect_rd("after_release", 32'd0, 5'd8, 32'd0, 5'd16);
    tick();
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
